u8inbuf: RTL

- Input-feature read responder for the u8 conv/dwconv datapath: answers the per-lane byte addresses and valid flags from the address generator with pixel bytes.
- Per-lane one-word (32-bit) line buffer with tags; misses are filled through a single shared word-read memory port.
- Backpressures the generator through a registered in_rdy. The generator holds its last accepted address while in_rdy is low.

---
 rtl/u8inbuf_if.sv | 26 ++
 rtl/u8inbuf.sv | 135 +++++++++++++
 2 files changed

// File: rtl/u8inbuf_if.sv
// Generator and memory-port bundle for u8inbuf; master = generator/memory side, slave = responder.
interface u8inbuf_if #(
  parameter int Np = 1,
  parameter int AW = 24
);
  logic [Np-1:0][AW-1:0] in_adr;
  logic [Np-1:0]         valid;
  logic                  in_rdy;
  logic [Np-1:0][7:0]    in_data;
  logic [Np-1:0]         in_dvalid;
  logic                  mem_req;
  logic [AW-3:0]         mem_adr;
  logic                  mem_gnt;
  logic                  mem_rvalid;
  logic [31:0]           mem_rdata;

  modport master (
    output in_adr, valid, mem_gnt, mem_rvalid, mem_rdata,
    input  in_rdy, in_data, in_dvalid, mem_req, mem_adr
  );

  modport slave (
    input  in_adr, valid, mem_gnt, mem_rvalid, mem_rdata,
    output in_rdy, in_data, in_dvalid, mem_req, mem_adr
  );
endinterface

// File: rtl/u8inbuf.sv
// Per-lane one-word tagged input buffer answering byte reads; misses filled via one shared word port.
// Optional hit/miss counters enabled by U8INBUF_STATS_EN.
module u8inbuf #(
  parameter int Np = 1,
  parameter int AW = 24
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        kick,
`ifdef U8INBUF_STATS_EN
  output logic [23:0] hit_cnt,
  output logic [23:0] miss_cnt,
`endif
  u8inbuf_if.slave    bus
);

  typedef enum logic [1:0] {SERVE, FILL, WAIT, RESP} state_t;

  state_t                state;
  logic [Np-1:0][AW-3:0] tag;
  logic [Np-1:0]         tag_v;
  logic [Np-1:0][31:0]   word;
  logic [Np-1:0][AW-1:0] pend_adr;
  logic [Np-1:0]         pend_vld;

  logic [Np-1:0]         in_hit;
  logic [Np-1:0]         pend_miss;
  logic [Np-1:0]         still_miss;
  logic [AW-3:0]         sel_wadr;
  logic                  rdata_take;

  always_comb begin
    in_hit     = '0;
    pend_miss  = '0;
    still_miss = '0;
    sel_wadr   = pend_adr[0][AW-1:2];
    for (int i = 0; i < Np; i++) begin
      in_hit[i]     = !bus.valid[i] ||
                      (tag_v[i] && !kick && tag[i] == bus.in_adr[i][AW-1:2]);
      pend_miss[i]  = pend_vld[i] && !(tag_v[i] && tag[i] == pend_adr[i][AW-1:2]);
      still_miss[i] = pend_miss[i] && (pend_adr[i][AW-1:2] != bus.mem_adr);
    end
    // descending scan so the lowest missing lane wins
    for (int i = Np - 1; i >= 0; i--) begin
      if (pend_miss[i]) sel_wadr = pend_adr[i][AW-1:2];
    end
  end

  // grant and data in the same cycle is taken as grant-then-data
  assign rdata_take = bus.mem_rvalid &&
                      ((state == WAIT) || (state == FILL && bus.mem_req && bus.mem_gnt));

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= SERVE;
      bus.in_rdy    <= 1'b1;
      bus.in_data   <= '0;
      bus.in_dvalid <= '0;
      bus.mem_req   <= 1'b0;
      bus.mem_adr   <= '0;
      tag           <= '0;
      tag_v         <= '0;
      word          <= '0;
      pend_adr      <= '0;
      pend_vld      <= '0;
    end else begin
      case (state)
        SERVE: begin
          if (&in_hit) begin
            for (int i = 0; i < Np; i++) begin
              bus.in_data[i] <= bus.valid[i] ?
                                word[i][{bus.in_adr[i][1:0], 3'b000} +: 8] : 8'h00;
            end
            bus.in_dvalid <= bus.valid;
          end else begin
            pend_adr      <= bus.in_adr;
            pend_vld      <= bus.valid;
            bus.in_rdy    <= 1'b0;
            bus.in_dvalid <= '0;
            bus.in_data   <= '0;
            state         <= FILL;
          end
        end
        FILL: begin
          if (!bus.mem_req) begin
            bus.mem_req <= 1'b1;
            bus.mem_adr <= sel_wadr;
          end else if (bus.mem_gnt) begin
            bus.mem_req <= 1'b0;
            if (!rdata_take) state <= WAIT;
          end
        end
        WAIT: begin
        end
        RESP: begin
          for (int i = 0; i < Np; i++) begin
            bus.in_data[i] <= pend_vld[i] ?
                              word[i][{pend_adr[i][1:0], 3'b000} +: 8] : 8'h00;
          end
          bus.in_dvalid <= pend_vld;
          bus.in_rdy    <= 1'b1;
          state         <= SERVE;
        end
        default: state <= SERVE;
      endcase

      // one fetch fills every pending lane that shares the word
      if (rdata_take) begin
        for (int i = 0; i < Np; i++) begin
          if (pend_vld[i] && pend_adr[i][AW-1:2] == bus.mem_adr) begin
            word[i]  <= bus.mem_rdata;
            tag[i]   <= bus.mem_adr;
            tag_v[i] <= 1'b1;
          end
        end
        state <= (|still_miss) ? FILL : RESP;
      end

      if (kick) tag_v <= '0;
    end
  end

`ifdef U8INBUF_STATS_EN
  always_ff @(posedge clk) begin
    if (rst || kick) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if (state == SERVE && (&in_hit) && hit_cnt != 24'hFFFFFF) hit_cnt <= hit_cnt + 24'd1;
      if (rdata_take && miss_cnt != 24'hFFFFFF) miss_cnt <= miss_cnt + 24'd1;
    end
  end
`endif

endmodule
